// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, fixed-latency memory between the fetch port and the
// load/store port; returns read data/acks to the owner and stalls the core meanwhile.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1,
  parameter int DATA_PRIO = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall
);

  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be within 1..7");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [2:0] lat_cnt_q, lat_cnt_d;
  // owner/rr_last encoding: 0 = fetch port, 1 = data port
  logic       owner_q, owner_d;
  logic       owner_we_q, owner_we_d;
  logic       rr_last_q, rr_last_d;
  logic       rsp_fire, win_ok, pick_d, grant_if, grant_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      owner_q    <= 1'b0;
      owner_we_q <= 1'b0;
      rr_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      owner_q    <= owner_d;
      owner_we_q <= owner_we_d;
      rr_last_q  <= rr_last_d;
    end
  end

  always_comb begin
    rsp_fire = (state_q == BUSY) && (lat_cnt_q == 3'd0);
    // The response cycle doubles as a grant cycle so back-to-back accesses have no bubble
    win_ok   = rst && ((state_q == IDLE) || rsp_fire);
    if (if_req && d_req) pick_d = (DATA_PRIO != 0) ? 1'b1 : ~rr_last_q;
    else                 pick_d = d_req;
    grant_d  = win_ok & d_req & pick_d;
    grant_if = win_ok & if_req & ~pick_d;

    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    owner_d    = owner_q;
    owner_we_d = owner_we_q;
    rr_last_d  = rr_last_q;
    if (grant_if || grant_d) begin
      state_d    = BUSY;
      lat_cnt_d  = 3'(MEM_LAT - 1);
      owner_d    = grant_d;
      owner_we_d = grant_d & d_we;
      rr_last_d  = grant_d;
    end else if (rsp_fire) begin
      state_d    = IDLE;
    end else if (state_q == BUSY) begin
      lat_cnt_d  = lat_cnt_q - 3'd1;
    end
  end

  always_comb begin
    if_gnt    = grant_if;
    d_gnt     = grant_d;
    mem_req   = grant_if | grant_d;
    mem_we    = grant_d & d_we;
    mem_be    = grant_d ? d_be    : (grant_if ? '1 : '0);
    mem_addr  = grant_d ? d_addr  : (grant_if ? if_addr : '0);
    mem_wdata = grant_d ? d_wdata : '0;

    if_rvalid = rsp_fire & ~owner_q;
    d_rvalid  = rsp_fire & owner_q;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !owner_we_q) ? mem_rdata : '0;

    stall = rst & ((if_req & ~if_gnt) | (d_req & ~d_gnt) |
                   ((state_q == BUSY) & (lat_cnt_q != 3'd0)));
  end

  // A waiting requester must hold its fields until granted
  a_if_hold: assert property (@(posedge clk) disable iff (!rst)
    (if_req && !if_gnt) |=> (!if_req || $stable(if_addr)));
  a_d_hold: assert property (@(posedge clk) disable iff (!rst)
    (d_req && !d_gnt) |=> (!d_req || $stable({d_we, d_be, d_addr, d_wdata})));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: three instances cover fixed-priority MEM_LAT=1,
// round-robin MEM_LAT=1 and fixed-priority MEM_LAT=3.
module tb_mem_port_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [N];
  logic        if_req    [N];
  logic [31:0] if_addr   [N];
  logic        if_gnt    [N];
  logic        if_rvalid [N];
  logic [31:0] if_rdata  [N];
  logic        d_req     [N];
  logic        d_we      [N];
  logic [3:0]  d_be      [N];
  logic [31:0] d_addr    [N];
  logic [31:0] d_wdata   [N];
  logic        d_gnt     [N];
  logic        d_rvalid  [N];
  logic [31:0] d_rdata   [N];
  logic        mem_req   [N];
  logic        mem_we    [N];
  logic [3:0]  mem_be    [N];
  logic [31:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];
  logic        stall     [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32),
      .MEM_LAT((g == 2) ? 3 : 1), .DATA_PRIO((g == 1) ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst(rst[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_be(d_be[g]), .d_addr(d_addr[g]),
      .d_wdata(d_wdata[g]), .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .stall(stall[g])
    );
  end

  // Event kinds: 0 fetch grant, 1 data grant, 2 fetch rvalid, 3 data rvalid
  typedef struct {
    int          k;
    int          cyc;
    int          kind;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } ev_t;

  ev_t sb_q[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_pat(int k, int c);
    return (32'(k + 1) << 28) | 32'(c);
  endfunction

  always_comb for (int k = 0; k < N; k++) mem_rdata[k] = rd_pat(k, cyc);

  task automatic chk(string nm, int k, logic [95:0] act, logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic exp_g(int k, int c, int kind, logic [31:0] a, logic we, logic [3:0] be,
                       logic [31:0] wd);
    ev_t e;
    e.k = k; e.cyc = c; e.kind = kind; e.addr = a; e.we = we; e.be = be; e.wd = wd;
    sb_q.push_back(e);
  endtask

  task automatic exp_r(int k, int c, int kind, logic [31:0] d);
    exp_g(k, c, kind, d, 1'b0, 4'h0, 32'h0);
  endtask

  // Monitor: pops one scoreboard entry per presented grant/rvalid, checks idle outputs otherwise
  always @(negedge clk) begin
    ev_t  e;
    logic fired;
    for (int k = 0; k < N; k++) begin
      for (int kind = 0; kind < 4; kind++) begin
        case (kind)
          0:       fired = if_gnt[k];
          1:       fired = d_gnt[k];
          2:       fired = if_rvalid[k];
          default: fired = d_rvalid[k];
        endcase
        if (fired) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_event", k, 96'(kind), 96'hFF);
          end else begin
            e = sb_q.pop_front();
            chk("event_id", k, {32'(k), 32'(cyc), 32'(kind)}, {32'(e.k), 32'(e.cyc), 32'(e.kind)});
            if (kind < 2)
              chk("grant_fields", k, {mem_req[k], mem_we[k], mem_be[k], mem_addr[k], mem_wdata[k]},
                  {1'b1, e.we, e.be, e.addr, e.wd});
            else
              chk("rdata", k, (kind == 2) ? if_rdata[k] : d_rdata[k], e.addr);
          end
        end
      end
      if (!if_gnt[k] && !d_gnt[k])
        chk("mem_idle", k, {mem_req[k], mem_we[k], mem_be[k], mem_addr[k], mem_wdata[k]}, '0);
      if (!if_rvalid[k]) chk("if_rdata_idle", k, if_rdata[k], '0);
      if (!d_rvalid[k])  chk("d_rdata_idle", k, d_rdata[k], '0);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int c0;
    logic s7 [7];
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_be[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    repeat (2) nxt();
    // Requests during reset must not produce any output
    for (int k = 0; k < N; k++) begin
      if_req[k] = 1'b1; d_req[k] = 1'b1; d_be[k] = 4'hF; d_addr[k] = 32'h40;
    end
    mid();
    for (int k = 0; k < N; k++)
      chk("reset_outputs", k, {if_gnt[k], d_gnt[k], mem_req[k], stall[k], if_rvalid[k], d_rvalid[k]}, '0);
    nxt();
    for (int k = 0; k < N; k++) begin if_req[k] = 1'b0; d_req[k] = 1'b0; rst[k] = 1'b1; end
    mid();
    for (int k = 0; k < N; k++) chk("idle_stall", k, stall[k], 0);
    nxt();

    // Single fetch, MEM_LAT=1
    c0 = cyc;
    if_req[0] = 1'b1; if_addr[0] = 32'h8000_0000;
    exp_g(0, c0, 0, 32'h8000_0000, 1'b0, 4'hF, 32'h0);
    exp_r(0, c0 + 1, 2, rd_pat(0, c0 + 1));
    mid(); chk("fetch_stall_c0", 0, stall[0], 0);
    nxt(); if_req[0] = 1'b0;
    mid(); chk("fetch_stall_c1", 0, stall[0], 0);
    nxt();

    // Tie with data priority: data first, fetch granted in the data response cycle
    c0 = cyc;
    if_req[0] = 1'b1; if_addr[0] = 32'h8000_0004;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_be[0] = 4'hF; d_addr[0] = 32'h100; d_wdata[0] = '0;
    exp_g(0, c0, 1, 32'h100, 1'b0, 4'hF, 32'h0);
    exp_g(0, c0 + 1, 0, 32'h8000_0004, 1'b0, 4'hF, 32'h0);
    exp_r(0, c0 + 1, 3, rd_pat(0, c0 + 1));
    exp_r(0, c0 + 2, 2, rd_pat(0, c0 + 2));
    mid(); chk("tie_stall_c0", 0, stall[0], 1);
    nxt(); d_req[0] = 1'b0;
    mid(); chk("tie_stall_c1", 0, stall[0], 0);
    nxt(); if_req[0] = 1'b0;
    mid(); chk("tie_stall_c2", 0, stall[0], 0);
    nxt();

    // Store: write fields on the memory side, zero read data on the ack
    c0 = cyc;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_be[0] = 4'b0011; d_addr[0] = 32'h200;
    d_wdata[0] = 32'hDEAD_BEEF;
    exp_g(0, c0, 1, 32'h200, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    exp_r(0, c0 + 1, 3, 32'h0);
    mid(); chk("store_stall", 0, stall[0], 0);
    nxt(); d_req[0] = 1'b0; d_we[0] = 1'b0; d_wdata[0] = '0;
    mid(); nxt();

    // Reset during an outstanding fetch discards it
    c0 = cyc;
    if_req[0] = 1'b1; if_addr[0] = 32'h8000_0010;
    exp_g(0, c0, 0, 32'h8000_0010, 1'b0, 4'hF, 32'h0);
    nxt(); if_req[0] = 1'b0; rst[0] = 1'b0;
    d_req[0] = 1'b1; d_be[0] = 4'hF; d_addr[0] = 32'h300;
    mid();
    chk("rst_mid_outputs", 0, {if_rvalid[0], d_gnt[0], mem_req[0], stall[0], if_rdata[0]}, '0);
    nxt(); d_req[0] = 1'b0;
    mid(); chk("rst_mid_rvalid", 0, {if_rvalid[0], d_rvalid[0], stall[0]}, '0);
    nxt(); rst[0] = 1'b1;
    mid(); chk("post_rst_rvalid", 0, {if_rvalid[0], d_rvalid[0], stall[0]}, '0);
    nxt();
    c0 = cyc;
    if_req[0] = 1'b1; if_addr[0] = 32'h8000_0000;
    exp_g(0, c0, 0, 32'h8000_0000, 1'b0, 4'hF, 32'h0);
    exp_r(0, c0 + 1, 2, rd_pat(0, c0 + 1));
    mid(); chk("post_rst_stall", 0, stall[0], 0);
    nxt(); if_req[0] = 1'b0;
    mid(); nxt();

    // Round robin: both held 8 cycles, grants alternate D,I,D,I one per cycle
    c0 = cyc;
    if_req[1] = 1'b1; if_addr[1] = 32'h0000_0000;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_be[1] = 4'hF; d_addr[1] = 32'h400; d_wdata[1] = '0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) begin
        exp_g(1, c0 + i, 0, 32'h0, 1'b0, 4'hF, 32'h0);
        exp_r(1, c0 + i, 3, rd_pat(1, c0 + i));
      end else begin
        exp_g(1, c0 + i, 1, 32'h400, 1'b0, 4'hF, 32'h0);
        if (i > 0) exp_r(1, c0 + i, 2, rd_pat(1, c0 + i));
      end
    end
    exp_r(1, c0 + 8, 2, rd_pat(1, c0 + 8));
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin if_req[1] = 1'b0; d_req[1] = 1'b0; end
      mid(); chk("rr_stall", 1, stall[1], (i < 8) ? 1 : 0);
      nxt();
    end

    // MEM_LAT=3: data request waits out the fetch, then its own latency stalls the core
    c0 = cyc;
    s7 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    if_req[2] = 1'b1; if_addr[2] = 32'h8000_0020;
    exp_g(2, c0, 0, 32'h8000_0020, 1'b0, 4'hF, 32'h0);
    exp_g(2, c0 + 3, 1, 32'h500, 1'b0, 4'hF, 32'h0);
    exp_r(2, c0 + 3, 2, rd_pat(2, c0 + 3));
    exp_r(2, c0 + 6, 3, rd_pat(2, c0 + 6));
    for (int i = 0; i < 7; i++) begin
      if (i == 1) begin
        if_req[2] = 1'b0;
        d_req[2] = 1'b1; d_we[2] = 1'b0; d_be[2] = 4'hF; d_addr[2] = 32'h500; d_wdata[2] = '0;
      end
      if (i == 4) d_req[2] = 1'b0;
      mid(); chk("lat3_stall", 2, stall[2], s7[i]);
      nxt();
    end

    repeat (3) nxt();
    chk("scoreboard_drained", 0, 96'(sb_q.size()), 96'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
